// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 active-low key matrix one row at a time, assembles a full
// 16-bit frame every four rows, debounces whole frames, and reports a single
// pressed key as a one-hot vector plus its binary index. Frames with no key
// or with several keys (ghosting) both report an empty one-hot vector.
//
// Parameters
//    TICK_DIV  - clk cycles each row is driven before its columns are sampled
//    DEBOUNCE  - identical consecutive frames needed to accept a state (2..15)
//
// Ports
//    clk       - system clock, rising edge
//    rst_n     - asynchronous active-low reset
//    col       - column lines, active-low, asynchronous to clk
//    row       - row drive, active-low, exactly one bit low
//    onehot    - accepted key, bit 4*r+c, zero when no single key is accepted
//    key_code  - index of the last accepted single key, held after release
//    key_valid - one-cycle pulse when a new single key is accepted
// -----------------------------------------------------------------------------
module keypad_scan #(
   parameter int TICK_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [15:0] onehot,
   output logic [3:0]  key_code,
   output logic        key_valid
);

   localparam int             DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [3:0]     CNT_LAST = 4'(DEBOUNCE - 1);

   logic [3:0]       col_meta_q, col_meta_d;
   logic [3:0]       col_sync_q, col_sync_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       r_q, r_d;
   logic [15:0]      raw_q, raw_d;
   logic [15:0]      prev_q, prev_d;
   logic [3:0]       stable_cnt_q, stable_cnt_d;
   logic             accept_q, accept_d;
   logic [15:0]      accept_snap_q, accept_snap_d;
   logic [15:0]      onehot_q, onehot_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;

   logic             tick;
   logic             frame_end;
   logic             single_key;
   logic [3:0]       single_idx;

   // Scan path: synchronize the columns, step the row divider, collect the
   // frame and run the frame-level debounce counter. Once the row-3 nibble is
   // written, raw_d is exactly the frame snapshot, so it is compared directly.
   always_comb begin
      col_meta_d    = col;
      col_sync_d    = col_meta_q;
      div_d         = div_q + 1'b1;
      r_d           = r_q;
      raw_d         = raw_q;
      prev_d        = prev_q;
      stable_cnt_d  = stable_cnt_q;
      accept_d      = 1'b0;
      accept_snap_d = accept_snap_q;

      tick      = (div_q == DIV_LAST);
      frame_end = tick && (r_q == 2'd3);

      if (tick) begin
         div_d = '0;
         r_d   = r_q + 2'd1;
         raw_d[{r_q, 2'b00} +: 4] = ~col_sync_q;
      end

      if (frame_end) begin
         if (raw_d == prev_q) begin
            if (stable_cnt_q != CNT_LAST) begin
               stable_cnt_d = stable_cnt_q + 4'd1;
            end
            // Accept only on the frame that reaches the threshold; frames
            // beyond it leave the outputs alone.
            if (stable_cnt_q == CNT_LAST - 4'd1) begin
               accept_d      = 1'b1;
               accept_snap_d = raw_d;
            end
         end else begin
            stable_cnt_d = '0;
         end
         prev_d = raw_d;
      end
   end

   // Output stage: decode the accepted snapshot one cycle after the frame
   // end. A snapshot counts as a key only when exactly one bit is set.
   always_comb begin
      onehot_d    = onehot_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      single_idx  = '0;

      single_key = (accept_snap_q != 16'd0) &&
                   ((accept_snap_q & (accept_snap_q - 16'd1)) == 16'd0);

      for (int i = 0; i < 16; i++) begin
         if (accept_snap_q[i]) begin
            single_idx = 4'(i);
         end
      end

      if (accept_q) begin
         if (single_key) begin
            onehot_d    = accept_snap_q;
            key_code_d  = single_idx;
            key_valid_d = (accept_snap_q != onehot_q);
         end else begin
            onehot_d = '0;
         end
      end
   end

   // State registers. The synchronizer idles at all-ones so an empty matrix
   // is seen immediately after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q    <= 4'hF;
         col_sync_q    <= 4'hF;
         div_q         <= '0;
         r_q           <= '0;
         raw_q         <= '0;
         prev_q        <= '0;
         stable_cnt_q  <= '0;
         accept_q      <= 1'b0;
         accept_snap_q <= '0;
         onehot_q      <= '0;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
      end else begin
         col_meta_q    <= col_meta_d;
         col_sync_q    <= col_sync_d;
         div_q         <= div_d;
         r_q           <= r_d;
         raw_q         <= raw_d;
         prev_q        <= prev_d;
         stable_cnt_q  <= stable_cnt_d;
         accept_q      <= accept_d;
         accept_snap_q <= accept_snap_d;
         onehot_q      <= onehot_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
      end
   end

   assign row       = ~(4'b0001 << r_q);
   assign onehot    = onehot_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//
// Drives keypad_scan through an ideal 4x4 key matrix and compares its outputs
// frame by frame against a frame-level model of the debounce and decode rules.
// Directed scenarios (single press, bounce, ghosting, release, direct change,
// mid-scan reset) are followed by randomized key sequences.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

   localparam int TICK_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] onehot;
   logic [3:0]  key_code;
   logic        key_valid;

   logic [15:0] keys;

   logic [15:0] mPrev;
   logic [15:0] mOnehot;
   logic [3:0]  mCode;
   int          mCnt;
   int          expPulses;
   int          seenPulses;

   int          checkCount;
   int          passCount;

   keypad_scan #(
      .TICK_DIV (TICK_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col       (col),
      .row       (row),
      .onehot    (onehot),
      .key_code  (key_code),
      .key_valid (key_valid)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Ideal matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row[r] && keys[4*r+c]) begin
               col[c] = 1'b0;
            end
         end
      end
   end

   // Count every cycle in which key_valid is seen high, well after the edge.
   always @(posedge clk) begin
      #1;
      if (rst_n && key_valid) begin
         seenPulses = seenPulses + 1;
      end
   end

   // Single comparison point: count it and report a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount = checkCount + 1;
      if (got === exp) begin
         passCount = passCount + 1;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame-level reference: DEBOUNCE identical frames accept a snapshot; a
   // single-key snapshot becomes the report, anything else clears it.
   task automatic modelFrame(input logic [15:0] snap);
      bit accepted;
      accepted = 1'b0;
      if (snap == mPrev) begin
         if (mCnt < DEBOUNCE - 1) begin
            mCnt = mCnt + 1;
            if (mCnt == DEBOUNCE - 1) accepted = 1'b1;
         end
      end else begin
         mCnt = 0;
      end
      mPrev = snap;
      if (accepted) begin
         if ($countones(snap) == 1) begin
            if (snap != mOnehot) expPulses = expPulses + 1;
            mOnehot = snap;
            for (int i = 0; i < 16; i++) begin
               if (snap[i]) mCode = 4'(i);
            end
         end else begin
            mOnehot = '0;
         end
      end
   endtask

   task automatic modelReset();
      mPrev   = '0;
      mOnehot = '0;
      mCode   = '0;
      mCnt    = 0;
   endtask

   // Wait for the next frame start, i.e. row 0 becoming driven again.
   task automatic waitFrameStart();
      int n;
      n = 0;
      while (row == 4'b1110 && n < 40) begin
         @(negedge clk);
         n++;
      end
      while (row != 4'b1110 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frame_sync_timeout", 32'(n >= 40), 32'd0);
   endtask

   // One scan frame with the given keys held, called at a frame start.
   // Outputs for the previous frame settle two cycles in and are checked.
   task automatic applyStimulus(input logic [15:0] k);
      keys = k;
      @(negedge clk);
      @(negedge clk);
      checkOutput("onehot", 32'(onehot), 32'(mOnehot));
      checkOutput("key_code", 32'(key_code), 32'(mCode));
      checkOutput("pulse_count", 32'(seenPulses), 32'(expPulses));
      waitFrameStart();
      modelFrame(k);
   endtask

   task automatic holdFrames(input logic [15:0] k, input int n);
      for (int i = 0; i < n; i++) applyStimulus(k);
   endtask

   function automatic logic [15:0] randomPattern();
      logic [15:0] p;
      int kind;
      kind = $urandom_range(0, 3);
      p = '0;
      if (kind >= 1) p[$urandom_range(0, 15)] = 1'b1;
      if (kind == 3) p[$urandom_range(0, 15)] = 1'b1;
      return p;
   endfunction

   initial begin
      checkCount = 0;
      passCount  = 0;
      seenPulses = 0;
      expPulses  = 0;
      modelReset();
      keys  = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_row", 32'(row), 32'h0000_000E);
      checkOutput("reset_onehot", 32'(onehot), 32'd0);
      checkOutput("reset_valid", 32'(key_valid), 32'd0);
      rst_n = 1'b1;

      $display("[TB] single press of key 6");
      holdFrames(16'h0000, 3);
      holdFrames(16'h0040, 6);

      $display("[TB] release, then press key 13");
      holdFrames(16'h0000, 5);
      holdFrames(16'h2000, 6);
      holdFrames(16'h0000, 4);

      $display("[TB] bounce on alternating frames");
      for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 16'h0040 : 16'h0000);
      holdFrames(16'h0000, 4);

      $display("[TB] ghosting with keys 3 and 7");
      holdFrames(16'h0088, 6);
      holdFrames(16'h0000, 4);

      $display("[TB] direct change from key 5 to key 10");
      holdFrames(16'h0020, 5);
      holdFrames(16'h0400, 5);

      $display("[TB] reset mid-scan with key held");
      holdFrames(16'h0040, 4);
      repeat (7) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_row", 32'(row), 32'h0000_000E);
      checkOutput("midreset_onehot", 32'(onehot), 32'd0);
      checkOutput("midreset_valid", 32'(key_valid), 32'd0);
      checkOutput("midreset_code", 32'(key_code), 32'd0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      holdFrames(16'h0040, 6);

      $display("[TB] randomized key sequences");
      for (int s = 0; s < 40; s++) begin
         holdFrames(randomPattern(), $urandom_range(1, 5));
      end
      holdFrames(16'h0000, 4);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles each row is driven (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE, default 4, meaning identical consecutive frames needed to accept a key state (range 2..15).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port col  input  4  matrix column lines; active-low; externally pulled up; asynchronous to clk.
REQ-006 SHALL have port row  output  4  matrix row drive; active-low; exactly one bit low at all times.
REQ-007 SHALL have port onehot  output  16  debounced key; bit (4*r+c) = row r, column c; all-zero when no key is accepted.
REQ-008 SHALL have port key_code  output  4  binary index of the last accepted key; holds after release.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse on acceptance of a new key.

Function
REQ-010 SHALL pass col through a 2-flop synchronizer before any sampling.
REQ-011 SHALL keep a divider counter 0..TICK_DIV-1 and a row index r in 0..3; row = ~(4'b0001 << r).
REQ-012 SHALL, on the cycle where the divider equals TICK_DIV-1, latch ~col_sync into raw[4r+3:4r], then clear the divider and advance r modulo 4.
REQ-013 SHALL treat the r=3 sample as frame end; the frame snapshot is {new row-3 nibble, stored rows 0-2}.
REQ-014 SHALL, at frame end, compare the snapshot with the previous snapshot: equal -> stable_cnt increments, saturating at DEBOUNCE-1; different -> stable_cnt = 0; then store the snapshot as previous.
REQ-015 SHALL accept the snapshot on the frame-end edge where stable_cnt reaches DEBOUNCE-1, so acceptance requires DEBOUNCE identical consecutive frames; later frames while stable change nothing.
REQ-016 SHALL, on acceptance with exactly one snapshot bit set, drive onehot = snapshot and key_code = that bit index.
REQ-017 SHALL, on acceptance of an all-zero snapshot or a snapshot with more than one bit set (ghosting), drive onehot = 0 and leave key_code unchanged.
REQ-018 SHALL drive key_valid high for exactly one cycle, on the cycle after acceptance, only when the newly accepted onehot is non-zero and differs from the previous onehot.
REQ-019 SHALL NOT pulse key_valid on release, on ghosting, or while a held key remains accepted.
REQ-020 SHALL update outputs registered, one cycle after the frame-end edge; worst-case press-to-onehot latency is (DEBOUNCE+1)*4*TICK_DIV+4 cycles.
REQ-021 SHALL apply a key-to-key change (A released, B pressed within one frame) as a new acceptance, with key_valid pulsing for B.

Reset
REQ-022 SHALL, while rst_n=0 and regardless of clk, set row=4'b1110, r=0, divider=0, raw=0, previous snapshot=0, stable_cnt=0, onehot=0, key_code=0, key_valid=0, and synchronizer flops to 4'b1111.
REQ-023 SHALL, when rst_n is asserted mid-frame or mid-debounce, discard partial frames, and scanning SHALL restart at row 0 with a full debounce on the first edge after release.

Verification (TICK_DIV=4, DEBOUNCE=3; frame = 16 cycles)
REQ-024 SHALL cover reset: rst_n=0 mid-scan with a key held -> row=1110, onehot=0000, key_valid=0 immediately; after release, onehot=0 for at least 3 full frames.
REQ-025 SHALL cover a single press: col=1011 only while row=1101, held steadily -> onehot=16'h0040, key_code=6, one key_valid pulse within 4 frames+4 cycles; no further pulse while held.
REQ-026 SHALL cover bounce: the same key present in alternating frames for 10 frames -> onehot stays 0000 and key_valid never asserts.
REQ-027 SHALL cover ghosting: keys 16'h0008 and 16'h0080 held together -> onehot=0000, key_valid never asserts, key_code unchanged.
REQ-028 SHALL cover release and re-press: after 16'h0040 is accepted and released, onehot returns to 0000 with no pulse; pressing 16'h2000 then gives key_code=13 and one pulse.
REQ-029 SHALL cover a direct change: 16'h0020 switched to 16'h0400 with no idle frame -> onehot=16'h0400 and a single key_valid pulse after 3 stable frames.
